// File: rtl/posit_pkg.sv
// posit_pkg: shared constants and stage bundles for the posit<16,1>
// arithmetic cluster (decoded operand, decoded pair, normalised product).
package posit_pkg;

   localparam int N  = 16;
   localparam int ES = 1;
   localparam int FW = 12;
   localparam int PW = 25;

   localparam logic [N-1:0] NAR    = 16'h8000;
   localparam logic [N-1:0] ZERO   = 16'h0000;
   localparam logic [N-1:0] MAXPOS = 16'h7FFF;
   localparam logic [N-1:0] MINPOS = 16'h0001;

   typedef struct packed {
      logic              sign;
      logic              is_zero;
      logic              is_nar;
      logic signed [6:0] scale;
      logic [FW:0]       frac;
   } posit_dec_t;

   typedef struct packed {
      posit_dec_t a;
      posit_dec_t b;
   } dec_pair_t;

   // frac holds PW bits below the hidden one of a product in [1,2)
   typedef struct packed {
      logic              sign;
      logic              is_nar;
      logic              is_zero;
      logic signed [6:0] scale;
      logic [PW-1:0]     frac;
   } prod_t;

endpackage

// File: rtl/posit_decode_16.sv
// posit_decode_16: combinational posit<16,1> field decoder.
// Ports: p (posit in), d (sign, zero/NaR flags, scale, 1.frac).
module posit_decode_16
   import posit_pkg::*;
(
   input  logic [N-1:0] p,
   output posit_dec_t   d
);

   logic [N-2:0]      v;
   logic              rb;
   logic              done;
   logic [4:0]        run;
   logic [N-4:0]      rest;
   logic signed [6:0] k;
   logic              e;

   always_comb begin
      v    = p[N-1] ? (~p[N-2:0] + 15'd1) : p[N-2:0];
      rb   = v[N-2];
      run  = 5'd0;
      done = 1'b0;
      for (int i = N-2; i >= 0; i--) begin
         if (!done) begin
            if (v[i] == rb) run = run + 5'd1;
            else            done = 1'b1;
         end
      end
      if (rb) k = $signed({2'b00, run}) - 7'sd1;
      else    k = 7'sd0 - $signed({2'b00, run});
      // bits 14:13 always belong to regime/terminator, so
      // the rest lines up under a shift of run-1
      rest = v[N-4:0] << (run - 5'd1);
      e    = rest[N-4];

      d.sign    = p[N-1];
      d.is_zero = (p == ZERO);
      d.is_nar  = (p == NAR);
      d.scale   = (k <<< ES) + $signed({6'd0, e});
      d.frac    = {1'b1, rest[N-5:0]};
   end

endmodule

// File: rtl/posit_multiplier_16.sv
// posit_multiplier_16: pipelined posit<16,1> multiplier, operand capture,
// S1 decode, S2 multiply/normalise, S3 round/encode into output register.
// Ports: clk, rst_n (async low), a/b + input_valid/input_ready in,
// r/inf/zero + output_valid/output_ready out. Global stall on a held
// output. POSIT_MUL_RNE_EN selects round-nearest-even, else truncation.
module posit_multiplier_16
   import posit_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         input_valid,
   output logic         input_ready,
   output logic [N-1:0] r,
   output logic         output_valid,
   input  logic         output_ready,
   output logic         inf,
   output logic         zero
);

`ifdef POSIT_MUL_RNE_EN
   localparam logic RNE_EN = 1'b1;
`else
   localparam logic RNE_EN = 1'b0;
`endif

   localparam int VW = 2 + 1 + PW + 16;

   logic         stall;
   logic         v0_q, v0_d;
   logic [N-1:0] opa_q, opa_d;
   logic [N-1:0] opb_q, opb_d;
   logic         v1_q, v1_d;
   dec_pair_t    s1_q, s1_d;
   logic         v2_q, v2_d;
   prod_t        s2_q, s2_d;
   logic         ov_q, ov_d;
   logic [N-1:0] r_q, r_d;
   logic         inf_q, inf_d;
   logic         zero_q, zero_d;

   posit_dec_t   dec_a, dec_b;
   prod_t        mul_res;
   logic [25:0]  prod;

   logic signed [4:0] k;
   logic              e;
   logic [VW-1:0]     vec;
   logic [N-2:0]      mag, mag_r;
   logic              guard, sticky, rnd;
   logic [N-1:0]      sum, res;
   logic [N-1:0]      enc_r;
   logic              enc_inf, enc_zero;

   posit_decode_16 u_dec_a (.p(opa_q), .d(dec_a));
   posit_decode_16 u_dec_b (.p(opb_q), .d(dec_b));

   assign input_ready  = ~stall;
   assign r            = r_q;
   assign inf          = inf_q;
   assign zero         = zero_q;
   assign output_valid = ov_q;

   // S2: 1.fa x 1.fb lies in [1,4); renormalise into [1,2)
   always_comb begin
      prod = {13'd0, s1_q.a.frac} * {13'd0, s1_q.b.frac};
      mul_res.sign    = s1_q.a.sign ^ s1_q.b.sign;
      mul_res.is_nar  = s1_q.a.is_nar | s1_q.b.is_nar;
      mul_res.is_zero = ~mul_res.is_nar
                      & (s1_q.a.is_zero | s1_q.b.is_zero);
      mul_res.scale   = s1_q.a.scale + s1_q.b.scale
                      + {6'd0, prod[25]};
      mul_res.frac    = prod[25] ? prod[24:0]
                                 : {prod[23:0], 1'b0};
   end

   // S3: regime is built by sign-extending "10" (k>=0) or
   // zero-extending "01" (k<0) over the exponent and fraction
   always_comb begin
      k = s2_q.scale[5:1];
      e = s2_q.scale[0];
      if (!k[4])
         vec = VW'($signed({2'b10, e, s2_q.frac, 16'd0}) >>> k[3:0]);
      else
         vec = {2'b01, e, s2_q.frac, 16'd0} >> (~k[3:0]);
      mag    = vec[VW-1:VW-15];
      guard  = vec[VW-16];
      sticky = |vec[VW-17:0];
      rnd    = RNE_EN & guard & (sticky | mag[0]);
      sum    = {1'b0, mag} + {15'd0, rnd};
      mag_r  = sum[N-1] ? MAXPOS[N-2:0] : sum[N-2:0];
      if (s2_q.scale > 7'sd28)
         mag_r = MAXPOS[N-2:0];
      else if (s2_q.scale < -7'sd28)
         mag_r = MINPOS[N-2:0];
      else if (mag_r == '0)
         mag_r = MINPOS[N-2:0];
      res = s2_q.sign ? (~{1'b0, mag_r} + 16'd1)
                      : {1'b0, mag_r};

      enc_r    = res;
      enc_inf  = 1'b0;
      enc_zero = 1'b0;
      if (s2_q.is_nar) begin
         enc_r   = NAR;
         enc_inf = 1'b1;
      end else if (s2_q.is_zero) begin
         enc_r    = ZERO;
         enc_zero = 1'b1;
      end
   end

   always_comb begin
      stall  = ov_q & ~output_ready;
      v0_d   = v0_q;
      opa_d  = opa_q;
      opb_d  = opb_q;
      v1_d   = v1_q;
      s1_d   = s1_q;
      v2_d   = v2_q;
      s2_d   = s2_q;
      ov_d   = ov_q;
      r_d    = r_q;
      inf_d  = inf_q;
      zero_d = zero_q;
      if (!stall) begin
         v0_d = input_valid;
         if (input_valid) begin
            opa_d = a;
            opb_d = b;
         end
         v1_d = v0_q;
         if (v0_q) begin
            s1_d.a = dec_a;
            s1_d.b = dec_b;
         end
         v2_d = v1_q;
         if (v1_q) s2_d = mul_res;
         ov_d = v2_q;
         if (v2_q) begin
            r_d    = enc_r;
            inf_d  = enc_inf;
            zero_d = enc_zero;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_q   <= 1'b0;
         opa_q  <= '0;
         opb_q  <= '0;
         v1_q   <= 1'b0;
         s1_q   <= '0;
         v2_q   <= 1'b0;
         s2_q   <= '0;
         ov_q   <= 1'b0;
         r_q    <= '0;
         inf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         v0_q   <= v0_d;
         opa_q  <= opa_d;
         opb_q  <= opb_d;
         v1_q   <= v1_d;
         s1_q   <= s1_d;
         v2_q   <= v2_d;
         s2_q   <= s2_d;
         ov_q   <= ov_d;
         r_q    <= r_d;
         inf_q  <= inf_d;
         zero_q <= zero_d;
      end
   end

endmodule

// File: tb/tb_posit_multiplier_16.sv
// tb_posit_multiplier_16: random and directed stimulus for the posit<16,1>
// multiplier, checked against a bit-string reference model.
module tb_posit_multiplier_16;

`ifdef POSIT_MUL_RNE_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        input_valid = 1'b0;
   logic        output_ready = 1'b1;
   logic        input_ready;
   logic        output_valid;
   logic        inf;
   logic        zero;
   logic [15:0] r;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [17:0] expq[$];
   logic [17:0] prev_out = '0;
   bit          prev_stall = 1'b0;

   posit_multiplier_16 dut (
      .clk(clk),
      .rst_n(rst_n),
      .a(a),
      .b(b),
      .input_valid(input_valid),
      .input_ready(input_ready),
      .r(r),
      .output_valid(output_valid),
      .output_ready(output_ready),
      .inf(inf),
      .zero(zero)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Value = mant * 2^(scale - fb), read bit by bit from the posit
   function automatic void dec(input logic [15:0] p, output int sc,
                               output longint mt, output int fb);
      logic [15:0] m;
      int i, run, k, e;
      bit rb;
      m = p[15] ? (16'h0000 - p) : p;
      rb = m[14];
      run = 0;
      i = 14;
      while (i >= 0 && m[i] == rb) begin run++; i--; end
      k = rb ? run - 1 : -run;
      i--;
      e = 0;
      if (i >= 0) begin e = int'(m[i]); i--; end
      mt = 1;
      fb = 0;
      while (i >= 0) begin mt = mt * 2 + longint'(m[i]); fb++; i--; end
      sc = 2 * k + e;
   endfunction

   // {inf, zero, r}: exact product emitted as an ideal posit bit string
   function automatic logic [17:0] model(input logic [15:0] x,
                                         input logic [15:0] y);
      int sx, sy, fx, fy, h, ts, k, e, mag;
      longint mx, my, m;
      bit q[$];
      bit neg, g, st;
      logic [15:0] m16;
      if (x == 16'h8000 || y == 16'h8000) return {2'b10, 16'h8000};
      if (x == 16'h0000 || y == 16'h0000) return {2'b01, 16'h0000};
      dec(x, sx, mx, fx);
      dec(y, sy, my, fy);
      neg = x[15] ^ y[15];
      m = mx * my;
      h = 0;
      while ((m >> (h + 1)) != 0) h++;
      ts = sx + sy + h - (fx + fy);
      if (ts > 28) mag = 32'h7fff;
      else if (ts < -28) mag = 1;
      else begin
         k = (ts >= 0) ? ts / 2 : -((1 - ts) / 2);
         e = ts - 2 * k;
         if (k >= 0) begin
            repeat (k + 1) q.push_back(1'b1);
            q.push_back(1'b0);
         end else begin
            repeat (-k) q.push_back(1'b0);
            q.push_back(1'b1);
         end
         q.push_back(e[0]);
         for (int j = h - 1; j >= 0; j--) q.push_back(m[j]);
         while (q.size() < 17) q.push_back(1'b0);
         mag = 0;
         for (int j = 0; j < 15; j++) mag = mag * 2 + int'(q[j]);
         g = q[15];
         st = 1'b0;
         for (int j = 16; j < q.size(); j++) st = st | q[j];
         if (RNE && g && (st || mag[0])) mag++;
         if (mag > 32'h7fff) mag = 32'h7fff;
         if (mag == 0) mag = 1;
      end
      m16 = mag[15:0];
      return {2'b00, neg ? (16'h0000 - m16) : m16};
   endfunction

   function automatic logic [15:0] rnd_op();
      logic [15:0] sp[8];
      sp = '{16'h0000, 16'h8000, 16'h7fff, 16'h0001,
             16'hffff, 16'h8001, 16'h4000, 16'hc000};
      if ($urandom_range(0, 4) == 0) return sp[$urandom_range(0, 7)];
      return 16'($urandom);
   endfunction

   // single compare process: ordering, values, hold and ready rules
   always @(negedge clk) begin
      logic [17:0] ex;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            check("hold", {13'd0, output_valid, inf, zero, r},
                  {13'd0, 1'b1, prev_out});
         check("ready", input_ready, !(output_valid && !output_ready));
         if (output_valid && output_ready) begin
            if (expq.size() == 0) begin
               check("spurious_valid", output_valid, 1'b0);
            end else begin
               ex = expq.pop_front();
               check("result", {inf, zero, r}, ex);
            end
         end
         if (input_valid && input_ready) expq.push_back(model(a, b));
         prev_stall = output_valid && !output_ready;
         prev_out = {inf, zero, r};
      end
   end

   task automatic send(input logic [15:0] x, input logic [15:0] y);
      int w;
      a = x;
      b = y;
      input_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!input_ready && w < 50) begin @(negedge clk); w++; end
      if (!input_ready) check("accept_timeout", input_ready, 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int w;
      w = 0;
      input_valid = 1'b0;
      output_ready = 1'b1;
      while (expq.size() != 0 && w < 100) begin @(posedge clk); w++; end
      #1;
      check("drain", expq.size(), 0);
   endtask

   logic [15:0] pa[12];
   logic [15:0] pb[12];
   logic [17:0] pr[12];
   int          lat;
   bit          got;
   bit          done;

   initial begin
      pa = '{16'h4000, 16'h4800, 16'hc000, 16'h8000, 16'h0000, 16'h0000,
             16'h7fff, 16'h0001, 16'hffff, 16'h4000, 16'h7fff, 16'hffff};
      pb = '{16'h5000, 16'h4800, 16'h5000, 16'h4000, 16'h8000, 16'h6000,
             16'h7fff, 16'h0001, 16'h0001, 16'h3000, 16'h0001, 16'hffff};
      pr = '{18'h05000, 18'h05200, 18'h0b000, 18'h28000, 18'h28000,
             18'h10000, 18'h07fff, 18'h00001, 18'h0ffff, 18'h03000,
             18'h04000, 18'h00001};

      #12;
      check("rst_valid", output_valid, 1'b0);
      check("rst_r", r, 16'h0000);
      check("rst_inf", inf, 1'b0);
      check("rst_zero", zero, 1'b0);
      check("rst_ready", input_ready, 1'b1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 12; i++)
         check("model_pin", model(pa[i], pb[i]), pr[i]);

      send(16'h4000, 16'h5000);
      input_valid = 1'b0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(negedge clk);
         if (output_valid) got = 1'b1;
         else begin @(posedge clk); lat++; end
      end
      check("latency", lat, 3);
      check("lat_r", {inf, zero, r}, 18'h05000);
      @(posedge clk);
      #1;
      drain();

      for (int i = 0; i < 12; i++) send(pa[i], pb[i]);
      drain();

      fork
         begin
            for (int i = 0; i < 8; i++) send(rnd_op(), rnd_op());
            input_valid = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1 output_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               check("stall_ready", input_ready, 1'b0);
            end
            @(posedge clk);
            #1 output_ready = 1'b1;
         end
      join
      drain();

      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               send(rnd_op(), rnd_op());
               if ($urandom_range(0, 3) == 0) begin
                  input_valid = 1'b0;
                  @(posedge clk);
                  #1;
               end
            end
            input_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 output_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();

      send(16'h4000, 16'h5000);
      send(16'h4800, 16'h4800);
      input_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", output_valid, 1'b0);
      check("mid_rst_r", r, 16'h0000);
      check("mid_rst_flags", {inf, zero}, 2'b00);
      expq.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         check("post_rst_valid", output_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      send(16'hc000, 16'h5000);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
